// File: rtl/adc_reader_pkg.sv
// Shared types, default parameters and counter-width helpers for the serial ADC reader.
package adc_reader_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DATA_BITS_DEF = 12;
  localparam int NULL_BITS_DEF = 2;
  localparam int HALF_CYC_DEF  = 2;
  localparam int SETUP_CYC_DEF = 2;
  localparam int GAP_CYC_DEF   = 4;
  localparam int FRAME_BITS    = NULL_BITS_DEF + DATA_BITS_DEF;

  // Total SCLK bit periods in one conversion frame.
  function automatic int frame_bits(input int nulls, input int data);
    return nulls + data;
  endfunction

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Half-period counter counts 0..HALF_CYC-1.
  function automatic int half_cnt_width(input int half_cyc);
    return cnt_width(half_cyc);
  endfunction

  // Bit counter must hold 0..frame so it is sized for frame+1 values.
  function automatic int bit_cnt_width(input int frame);
    return cnt_width(frame + 1);
  endfunction

endpackage

// File: rtl/adc_serial_reader_sclk_timer.sv
// SCLK generator: counts half periods while enabled and flags the rising edge
// (data capture point) and the end of each high phase (bit boundary).
module adc_sclk_timer
  import adc_reader_pkg::*;
#(
  parameter int HALF_CYC = HALF_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sclk,
  output logic rise_tick,
  output logic bit_done
);

  localparam int HW = half_cnt_width(HALF_CYC);

  logic [HW-1:0] half_cnt_reg;
  logic          sclk_reg;
  logic          half_end;

  assign half_end  = (half_cnt_reg == HW'(HALF_CYC - 1));
  // Both strobes describe what the coming edge does: rise = 0->1, done = 1->0.
  assign rise_tick = enable & half_end & ~sclk_reg;
  assign bit_done  = enable & half_end & sclk_reg;
  assign sclk      = sclk_reg;

  // Half-period counter and SCLK toggle; idle low whenever disabled.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      half_cnt_reg <= '0;
      sclk_reg     <= 1'b0;
    end else if (half_end) begin
      half_cnt_reg <= '0;
      sclk_reg     <= ~sclk_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + HW'(1);
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// Master-side reader for a 12-bit serial SAR ADC: frames CS_n/SCLK, shifts in
// null bits plus an MSB-first word and presents it with a one-cycle strobe.
module adc_serial_reader
  import adc_reader_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int NULL_BITS = NULL_BITS_DEF,
  parameter int HALF_CYC  = HALF_CYC_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  input  logic                 adc_dout,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 null_err,
  output logic                 busy
);

  localparam int NBITS   = frame_bits(NULL_BITS, DATA_BITS);
  localparam int BW      = bit_cnt_width(NBITS);
  localparam int CYC_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CW      = cnt_width(CYC_MAX);

  state_t                state_reg, state_next;
  logic [CW-1:0]         cyc_reg, cyc_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic                  cs_n_reg, cs_n_next;
  logic                  busy_reg, busy_next;
  logic                  valid_reg, valid_next;
  logic                  null_err_reg, null_err_next;
  logic                  null_bit_reg, null_bit_next;
  logic [DATA_BITS-1:0]  shreg_reg, shreg_next;
  logic [DATA_BITS-1:0]  sample_reg, sample_next;

  logic rise_tick;
  logic bit_done;

  adc_sclk_timer #(
    .HALF_CYC (HALF_CYC)
  ) u_sclk_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_reg == SHIFT),
    .sclk      (adc_sclk),
    .rise_tick (rise_tick),
    .bit_done  (bit_done)
  );

  assign adc_cs_n     = cs_n_reg;
  assign busy         = busy_reg;
  assign sample_valid = valid_reg;
  assign null_err     = null_err_reg;
  assign sample       = sample_reg;

  // State and datapath registers; reset aborts any partial frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cyc_reg      <= '0;
      bit_reg      <= '0;
      cs_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      null_err_reg <= 1'b0;
      null_bit_reg <= 1'b0;
      shreg_reg    <= '0;
      sample_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      bit_reg      <= bit_next;
      cs_n_reg     <= cs_n_next;
      busy_reg     <= busy_next;
      valid_reg    <= valid_next;
      null_err_reg <= null_err_next;
      null_bit_reg <= null_bit_next;
      shreg_reg    <= shreg_next;
      sample_reg   <= sample_next;
    end
  end

  // Frame sequencing, bit capture and result publication.
  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    bit_next      = bit_reg;
    cs_n_next     = cs_n_reg;
    busy_next     = busy_reg;
    valid_next    = 1'b0;
    null_err_next = null_err_reg;
    null_bit_next = null_bit_reg;
    shreg_next    = shreg_reg;
    sample_next   = sample_reg;

    case (state_reg)
      IDLE: begin
        if (start || continuous) begin
          state_next = SETUP;
          cs_n_next  = 1'b0;
          busy_next  = 1'b1;
          cyc_next   = '0;
        end
      end

      SETUP: begin
        if (cyc_reg == CW'(SETUP_CYC - 1)) begin
          state_next = SHIFT;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end

      SHIFT: begin
        // Only the last null bit matters; earlier ones are clocked and dropped.
        if (rise_tick) begin
          if (bit_reg < BW'(NULL_BITS)) begin
            if (bit_reg == BW'(NULL_BITS - 1)) begin
              null_bit_next = adc_dout;
            end
          end else begin
            shreg_next = {shreg_reg[DATA_BITS-2:0], adc_dout};
          end
        end
        if (bit_done) begin
          if (bit_reg == BW'(NBITS - 1)) begin
            bit_next      = '0;
            state_next    = GAP;
            cs_n_next     = 1'b1;
            sample_next   = shreg_reg;
            valid_next    = 1'b1;
            null_err_next = null_bit_reg;
            cyc_next      = '0;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end
      end

      GAP: begin
        if (cyc_reg == CW'(GAP_CYC - 1)) begin
          cyc_next = '0;
          if (continuous) begin
            state_next = SETUP;
            cs_n_next  = 1'b0;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Self-checking bench: behavioural ADC model, table-driven single frames,
// randomized continuous run and hand-written overlap / reset corner cases.
module tb_adc_serial_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_dout;
  logic [11:0] sample;
  logic        sample_valid;
  logic        null_err;
  logic        busy;

  always #5 clk = ~clk;

  adc_serial_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_dout     (adc_dout),
    .sample       (sample),
    .sample_valid (sample_valid),
    .null_err     (null_err),
    .busy         (busy)
  );

  typedef struct {
    logic [11:0] s;
    logic        e;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic [1:0]  nulls;
    logic [11:0] data;
    logic [11:0] exp_sample;
    logic        exp_err;
  } vec_t;

  strobe_t     got_q[$];
  logic [13:0] frame_q[$];
  logic [13:0] frame_reg = 14'h0;
  logic [3:0]  bit_idx;
  int rise_cnt = 0, cyc = 0, cs_low_cnt = 0, cs_high_cnt = 0;
  int last_cs_low = 0, last_rises = 0, last_cs_high = 0, last_busy_delay = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  // ADC model: a 14-bit frame (nulls then data, MSB first) is taken from the
  // queue at each CS_n fall; bit k is presented until the k-th SCLK rise.
  assign bit_idx  = 4'(13 - rise_cnt);
  assign adc_dout = (rise_cnt < 14) ? frame_reg[bit_idx] : 1'b0;

  // Monitor: interface timing measurements and strobe capture.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_cs   <= adc_cs_n;
    prev_sclk <= adc_sclk;
    prev_busy <= busy;
    if (adc_cs_n) begin
      rise_cnt    <= 0;
      cs_low_cnt  <= 0;
      cs_high_cnt <= cs_high_cnt + 1;
      if (!prev_cs) begin
        last_cs_low <= cs_low_cnt;
        last_rises  <= rise_cnt;
      end
    end else begin
      cs_high_cnt <= 0;
      cs_low_cnt  <= cs_low_cnt + 1;
      if (prev_cs) begin
        last_cs_high <= cs_high_cnt;
        rise_cnt     <= 0;
        if (frame_q.size() > 0) frame_reg <= frame_q.pop_front();
        else                    frame_reg <= 14'h0;
      end else if (adc_sclk && !prev_sclk) begin
        rise_cnt <= rise_cnt + 1;
      end
    end
    if (!busy && prev_busy) last_busy_delay <= cs_high_cnt;
    if (sample_valid) got_q.push_back('{sample, null_err, cyc});
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic get_strobe(input int budget, output strobe_t s, output bit ok);
    ok = 1'b0;
    s  = '{12'h0, 1'b0, 0};
    for (int i = 0; i < budget && !ok; i++) begin
      if (got_q.size() > 0) begin
        s  = got_q.pop_front();
        ok = 1'b1;
      end else begin
        tick(1);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout no sample_valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && busy !== 1'b0; i++) tick(1);
    chk("idle_reached", 32'(busy), 32'h0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t        vecs[6];
    strobe_t     s;
    bit          ok;
    logic [11:0] cwords[$];
    int          prev_cyc;
    int          n;
    int          i;

    vecs[0] = '{2'b10, 12'hA5C, 12'hA5C, 1'b0};
    vecs[1] = '{2'b10, 12'h000, 12'h000, 1'b0};
    vecs[2] = '{2'b10, 12'hFFF, 12'hFFF, 1'b0};
    vecs[3] = '{2'b11, 12'h123, 12'h123, 1'b1};
    vecs[4] = '{2'b10, 12'h3C3, 12'h3C3, 1'b0};
    vecs[5] = '{2'b01, 12'h0F0, 12'h0F0, 1'b1};

    // Reset state.
    tick(3);
    chk("rst_cs_n", 32'(adc_cs_n), 32'h1);
    chk("rst_sclk", 32'(adc_sclk), 32'h0);
    chk("rst_sample", 32'(sample), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_null_err", 32'(null_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(2);

    // Single-shot frames from the table.
    for (int k = 0; k < 6; k++) begin
      got_q.delete();
      frame_q.push_back({vecs[k].nulls, vecs[k].data});
      pulse_start();
      get_strobe(200, s, ok);
      if (ok) begin
        chk($sformatf("v%0d_sample", k), 32'(s.s), 32'(vecs[k].exp_sample));
        chk($sformatf("v%0d_null_err", k), 32'(s.e), 32'(vecs[k].exp_err));
      end
      wait_idle(20);
      chk($sformatf("v%0d_cs_low_cycles", k), last_cs_low, 58);
      chk($sformatf("v%0d_sclk_rises", k), last_rises, 14);
      chk($sformatf("v%0d_busy_delay", k), last_busy_delay, 4);
      tick(5);
      chk($sformatf("v%0d_one_strobe", k), got_q.size(), 0);
      chk($sformatf("v%0d_sample_hold", k), 32'(sample), 32'(vecs[k].exp_sample));
      $display("frame %0d data=0x%03h nulls=%b -> sample=0x%03h null_err=%0d", k, vecs[k].data, vecs[k].nulls, s.s, s.e);
    end

    // Continuous mode: fixed words then random ones; drop continuous mid-frame.
    cwords = '{12'h001, 12'h800, 12'h7FF};
    for (int k = 0; k < 4; k++) cwords.push_back(12'($urandom_range(0, 4095)));
    n = cwords.size();
    got_q.delete();
    foreach (cwords[k]) frame_q.push_back({2'b10, cwords[k]});
    continuous = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < n; k++) begin
      get_strobe(200, s, ok);
      if (!ok) break;
      chk($sformatf("cont%0d_sample", k), 32'(s.s), 32'(cwords[k]));
      chk($sformatf("cont%0d_null_err", k), 32'(s.e), 32'h0);
      if (k > 0) begin
        chk($sformatf("cont%0d_period", k), s.cyc - prev_cyc, 62);
        chk($sformatf("cont%0d_cs_high", k), last_cs_high, 4);
      end
      $display("cont frame %0d sample=0x%03h expected=0x%03h", k, s.s, cwords[k]);
      prev_cyc = s.cyc;
      if (k == n - 2) begin
        tick(10);
        continuous = 1'b0;
      end
    end
    wait_idle(100);
    tick(80);
    chk("cont_no_extra_strobe", got_q.size(), 0);
    chk("cont_cs_idle", 32'(adc_cs_n), 32'h1);
    chk("cont_frames_consumed", frame_q.size(), 0);

    // Start while busy is ignored, not queued.
    got_q.delete();
    frame_q.delete();
    frame_q.push_back({2'b10, 12'h5A5});
    frame_q.push_back({2'b10, 12'h111});
    for (int c = 0; c < 58; c++) begin
      start = (c == 0 || c == 10 || c == 57);
      tick(1);
    end
    start = 1'b0;
    get_strobe(200, s, ok);
    if (ok) chk("overlap_sample", 32'(s.s), 32'h5A5);
    wait_idle(20);
    tick(100);
    chk("overlap_one_strobe", got_q.size(), 0);
    chk("overlap_one_frame", frame_q.size(), 1);
    chk("overlap_idle", 32'(busy), 32'h0);
    $display("overlap sample=0x%03h", s.s);
    frame_q.delete();

    // Reset after the 6th SCLK rise.
    got_q.delete();
    frame_q.push_back({2'b10, 12'h777});
    pulse_start();
    for (i = 0; i < 100 && rise_cnt != 6; i++) tick(1);
    chk("rst_mid_reached_rise6", rise_cnt, 6);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_cs_n", 32'(adc_cs_n), 32'h1);
    chk("rst_mid_sclk", 32'(adc_sclk), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_valid", 32'(sample_valid), 32'h0);
    chk("rst_mid_sample", 32'(sample), 32'h0);
    reset = 1'b0;
    tick(70);
    chk("rst_mid_no_strobe", got_q.size(), 0);
    chk("rst_mid_stays_idle", 32'(busy), 32'h0);
    frame_q.delete();
    frame_q.push_back({2'b10, 12'h3C3});
    pulse_start();
    get_strobe(200, s, ok);
    if (ok) begin
      chk("post_rst_sample", 32'(s.s), 32'h3C3);
      chk("post_rst_null_err", 32'(s.e), 32'h0);
    end
    wait_idle(20);
    $display("post-reset frame sample=0x%03h", s.s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Master-side reader for a 12-bit serial-output SAR ADC (ADS7816-class: CS_n, DCLOCK, DOUT) on the PCB analog path.
- It is the input-direction companion of the DAC7611 serial writer in the same FPGA fabric. It drives CS_n and SCLK from the system clock and shifts in null bits plus a 12-bit MSB-first word.
- It presents each result as a parallel sample with a one-cycle valid strobe, triggered by a single start pulse or by free-running continuous mode.

Parameters:
- DATA_BITS, 12, data bits per frame, MSB first.
- NULL_BITS, 2, leading null bits clocked before the MSB; the last one must read 0.
- HALF_CYC, 2, clk cycles per SCLK half-period (SCLK = clk/(2*HALF_CYC)); minimum 1.
- SETUP_CYC, 2, clk cycles from CS_n fall to the first SCLK rise; minimum 1.
- GAP_CYC, 4, minimum clk cycles CS_n stays high between frames (conversion/quiet time); minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-frame request, sampled in IDLE only.
- continuous  input  1  when 1, a new frame starts automatically after GAP.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sclk  output  1  ADC serial clock, idles low.
- adc_dout  input  1  ADC serial data.
- sample  output  DATA_BITS  last completed conversion.
- sample_valid  output  1  one-cycle strobe when sample updates.
- null_err  output  1  registered with sample_valid; 1 if the last null bit read 1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. The reset port is named reset; it is synchronous and active-high.
- Values at reset: adc_cs_n=1, adc_sclk=0, sample=0, sample_valid=0, null_err=0, busy=0, state=IDLE, all counters=0. The same values apply on the edge after reset is asserted mid-frame; the partial frame is discarded and no valid strobe is issued.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE -> SETUP: on the edge where start=1 or continuous=1. At that edge adc_cs_n goes 0 and busy goes 1.
- SETUP: hold adc_sclk=0 for SETUP_CYC cycles, then move to SHIFT.
- SHIFT: NULL_BITS+DATA_BITS bit periods. Each bit period is HALF_CYC cycles of SCLK low followed by HALF_CYC cycles of SCLK high.
- Data capture: adc_dout is captured on the same clk edge that drives adc_sclk 0->1. The ADC updates DOUT after each SCLK fall, so setup time is HALF_CYC clk periods.
- Bit order: null bits are captured first (only the last is kept, for the error check). Data bits then shift into a DATA_BITS register MSB first.
- End of SHIFT, after the last high phase, all on one edge:
  - adc_sclk goes 0 and adc_cs_n goes 1;
  - sample loads the shift register and sample_valid pulses for one cycle;
  - null_err updates;
  - state moves to GAP.
- GAP: CS_n stays high for GAP_CYC cycles.
  - If continuous=1 on the last GAP cycle: go to SETUP, with CS_n falling on that edge.
  - Otherwise: go to IDLE, with busy falling on that edge.
- Frame timing with defaults: CS_n is low for SETUP_CYC + (NULL_BITS+DATA_BITS)*2*HALF_CYC = 58 cycles. The continuous-mode period is 58 + GAP_CYC = 62 cycles.
- start outside IDLE is ignored, not queued.
- Dropping continuous mid-frame completes the current frame, then returns to IDLE after GAP.
- start and continuous both high in IDLE start one frame only.
- sample holds its value between strobes.
- Counters: the half-period counter is clog2(HALF_CYC) bits wide. The bit counter is clog2(NULL_BITS+DATA_BITS+1) bits wide and wraps to 0 at frame end.

Decomposition:
- Shared package adc_reader_pkg holds:
  - the state enum (IDLE/SETUP/SHIFT/GAP);
  - FRAME_BITS = NULL_BITS+DATA_BITS;
  - the width functions for the counters.
- One sub-module, adc_sclk_timer. It owns the half-period counter and the SCLK toggle. It outputs rise_tick (capture strobe) and bit_done (end of high phase), gated by an enable from the FSM. The FSM, shift register and output registers stay in adc_serial_reader.

Test Plan:
- Single frame: the bench ADC model drives null bits 1,0 then 0xA5C; pulse start once. Required response:
  - sample=0xA5C, null_err=0, exactly one sample_valid;
  - CS_n low for exactly 58 cycles and exactly 14 SCLK rises;
  - busy falls 4 cycles after CS_n rises.
- Code extremes: frames returning 0x000 then 0xFFF -> sample=0x000, then 0xFFF; no bit-slip across frames.
- Continuous mode: continuous=1 with model words 0x001, 0x800, 0x7FF. Required response:
  - valid strobes 62 cycles apart;
  - CS_n high for exactly 4 cycles between frames;
  - samples match in order.
- Busy/overlap: pulse start at frame cycles 0, 10 and 57 -> only one frame runs and one strobe is seen. Then deassert continuous mid-frame -> that frame completes and the FSM returns to IDLE.
- Reset mid-frame: assert reset after the 6th SCLK rise. Required response:
  - next edge gives CS_n=1, SCLK=0, busy=0, no strobe, sample=0;
  - a following start yields a correct 0x3C3.
- Null error: the model drives the last null bit as 1 with data 0x123 -> sample=0x123 and null_err=1 on the strobe cycle; the next clean frame clears null_err.
